data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL take parameters: LINES, default 16, number of direct-mapped lines; WORDS, default 4, 32-bit words per line.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 MemRead  in  1  MEM-stage load request (from EX/MEM control).
REQ-005 MemWrite  in  1  MEM-stage store request.
REQ-006 Address  in  32  byte address from MEM-stage ALU result; bits [1:0] ignored.
REQ-007 Write_Data  in  32  store data from MEM-stage RT data.
REQ-008 Read_data  out  32  load data toward MEM/WB register.
REQ-009 Stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; bubbles MEM/WB while high.
REQ-010 mem_req, mem_we  out  1 each  backing-memory request and write qualifier.
REQ-011 mem_addr, mem_wdata  out  32 each  word-aligned memory address and write data.
REQ-012 mem_ready  in  1  memory accepts write, or returns one read word, this cycle.
REQ-013 mem_rdata  in  32  read word, valid when mem_ready=1.

Function
REQ-014 Address split SHALL be: offset = Address[3:2], index = Address[7:4], tag = Address[31:8] (defaults; widths follow parameters).
REQ-015 Policy SHALL be write-through, no-write-allocate, read-allocate; per line: valid bit, tag, WORDS data words.
REQ-016 FSM states SHALL be IDLE, REFILL, WRITE, WDONE.
REQ-017 IDLE, MemRead, hit: Read_data = cached word combinationally; Stall=0; state unchanged.
REQ-018 IDLE, MemRead, miss: Stall=1 same cycle; beat counter cleared; next state REFILL.
REQ-019 REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}, held stable until mem_ready; each mem_ready writes mem_rdata to word[beat] and increments beat; Stall=1 throughout.
REQ-020 Accepting the last beat (beat=WORDS-1) SHALL set valid and tag in the same edge and return to IDLE; the held load then hits.
REQ-021 IDLE, MemWrite: Stall=1; Address and Write_Data latched; next state WRITE.
REQ-022 WRITE: mem_req=1, mem_we=1, latched address/data driven; on mem_ready, if the line hits, the cached word is updated in the same edge; next state WDONE.
REQ-023 WDONE: Stall=0, no memory request; next state IDLE regardless of inputs, so the store is not reissued.
REQ-024 MemRead and MemWrite both high SHALL be treated as a store.
REQ-025 Neither MemRead nor MemWrite: Stall=0, mem_req=0, Read_data=0.
REQ-026 mem_req SHALL be 0 in IDLE and WDONE; mem_we=1 only in WRITE.
REQ-027 With mem_ready held high: load miss SHALL stall 1+WORDS cycles (5); store SHALL stall 2 cycles.

Reset
REQ-028 RESET=1 SHALL clear all valid bits, force IDLE, beat=0, latches 0; outputs Stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Read_data=0.
REQ-029 RESET during REFILL or WRITE SHALL abort the transaction at that edge; the partially filled line SHALL remain invalid.
REQ-030 Data array contents SHALL NOT need reset.

Structure
REQ-031 Shared package mips_mem_pkg SHALL hold the FSM state type, LINES/WORDS defaults and tag/index/offset widths.
REQ-032 Storage SHALL be one sub-module data_cache_array (valid/tag/data, one read port, one word write port, bulk invalidate); FSM stays in data_cache.

Verification
REQ-033 Load 0x100 cold, mem returns 0xA0..0xA3 with ready always 1 -> Stall high 5 cycles, mem_addr 0x100,0x104,0x108,0x10C, Read_data=0xA0.
REQ-034 Load 0x108 after REQ-033 -> Stall=0, Read_data=0xA2, mem_req=0.
REQ-035 Store 0xDEAD to 0x104 (hit) -> one write with mem_we=1, addr 0x104; Stall 2 cycles; then load 0x104 returns 0xDEAD without miss.
REQ-036 Store to 0x900 (miss), then load 0x900 -> store not allocated; load refills from 0x900.
REQ-037 Load 0x200 miss, assert RESET after 2 beats -> mem_req=0 next cycle, IDLE; reload 0x200 refills all 4 beats.
REQ-038 Load 0x100 then 0x500 (same index, different tag), mem_ready toggling 1/0 -> addresses held stable while ready=0; line replaced; 0x100 misses again.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data cache: geometry defaults, field widths
// and the controller state type.
package mips_mem_pkg;

  localparam int unsigned LINES_DEF    = 16;
  localparam int unsigned WORDS_DEF    = 4;
  localparam int unsigned OFFSET_W_DEF = $clog2(WORDS_DEF);
  localparam int unsigned INDEX_W_DEF  = $clog2(LINES_DEF);
  localparam int unsigned TAG_W_DEF    = 32 - INDEX_W_DEF - OFFSET_W_DEF - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_WDONE  = 2'd3
  } cache_state_t;

  function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
    return 32 - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Direct-mapped line storage: valid/tag per line plus WORDS data words, one combinational
// read port, one word write port, a tag/valid update port and a bulk invalidate.
module data_cache_array
  import mips_mem_pkg::*;
#(
  parameter  int unsigned LINES = LINES_DEF,
  parameter  int unsigned WORDS = WORDS_DEF,
  parameter  int unsigned TAG_W = TAG_W_DEF,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned OFF_W = $clog2(WORDS)
) (
  input  logic             i_clk,
  input  logic             i_inval,
  input  logic [IDX_W-1:0] i_index,
  input  logic [OFF_W-1:0] i_rd_offset,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_word,
  input  logic             i_word_we,
  input  logic [OFF_W-1:0] i_wr_offset,
  input  logic [31:0]      i_wr_word,
  input  logic             i_tag_we,
  input  logic             i_tag_valid,
  input  logic [TAG_W-1:0] i_tag
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS];

  assign o_rd_valid = r_valid[i_index];
  assign o_rd_tag   = r_tag[i_index];
  assign o_rd_word  = r_data[i_index][i_rd_offset];

  always_ff @(posedge i_clk) begin
    if (i_inval) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_index] <= i_tag_valid;
    end
  end

  // Tag and data contents are meaningless until the valid bit says otherwise.
  always_ff @(posedge i_clk) begin
    if (i_tag_we) begin
      r_tag[i_index] <= i_tag;
    end
    if (i_word_we) begin
      r_data[i_index][i_wr_offset] <= i_wr_word;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Write-through, read-allocate direct-mapped data cache sitting in the MEM stage;
// stalls the pipeline while a line refills or a store goes out to backing memory.
//   state  | meaning
//   IDLE   | serve load hits; detect load miss or store
//   REFILL | fetch WORDS beats of the missing line
//   WRITE  | push latched store to memory, update line on hit
//   WDONE  | release stall one cycle so the store is not reissued
module data_cache
  import mips_mem_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_data,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = tag_width(LINES, WORDS);
  localparam int unsigned IDX_LO = 2 + OFF_W;
  localparam int unsigned TAG_LO = IDX_LO + IDX_W;

  cache_state_t     r_state, w_next;
  logic [OFF_W-1:0] r_beat;
  logic [31:2]      r_addr;
  logic [31:0]      r_wdata;

  logic [31:0]      w_lk_addr;
  logic [IDX_W-1:0] w_index;
  logic [OFF_W-1:0] w_offset;
  logic [TAG_W-1:0] w_tag;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_word;
  logic             w_hit;
  logic             w_last;
  logic             w_word_we;
  logic [OFF_W-1:0] w_wr_offset;
  logic [31:0]      w_wr_word;
  logic             w_tag_we;
  logic             w_tag_valid;
  logic             w_unused;

  // A pending store looks up the line with its latched address, everything else with the live one.
  assign w_lk_addr = (r_state == S_WRITE) ? {r_addr, 2'b00} : Address;
  assign w_index   = w_lk_addr[TAG_LO-1:IDX_LO];
  assign w_offset  = w_lk_addr[IDX_LO-1:2];
  assign w_tag     = w_lk_addr[31:TAG_LO];
  assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
  assign w_last    = (r_beat == OFF_W'(WORDS - 1));
  assign w_unused  = ^{Address[1:0], w_lk_addr[1:0]};

  data_cache_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .TAG_W(TAG_W)
  ) u_array (
    .i_clk      (CLK),
    .i_inval    (RESET),
    .i_index    (w_index),
    .i_rd_offset(w_offset),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_word  (w_rd_word),
    .i_word_we  (w_word_we),
    .i_wr_offset(w_wr_offset),
    .i_wr_word  (w_wr_word),
    .i_tag_we   (w_tag_we),
    .i_tag_valid(w_tag_valid),
    .i_tag      (w_tag)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && MemWrite) begin
        r_addr  <= Address[31:2];
        r_wdata <= Write_Data;
      end
      if (r_state == S_IDLE) begin
        r_beat <= '0;
      end else if (r_state == S_REFILL && mem_ready) begin
        r_beat <= r_beat + OFF_W'(1);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    Stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    Read_data   = '0;
    w_word_we   = 1'b0;
    w_wr_offset = w_offset;
    w_wr_word   = r_wdata;
    w_tag_we    = 1'b0;
    w_tag_valid = 1'b0;
    if (!RESET) begin
      case (r_state)
        S_IDLE: begin
          if (MemWrite) begin
            Stall  = 1'b1;
            w_next = S_WRITE;
          end else if (MemRead) begin
            if (w_hit) begin
              Read_data = w_rd_word;
            end else begin
              // Drop the old line now so an aborted refill never leaves a half-valid line.
              Stall    = 1'b1;
              w_tag_we = 1'b1;
              w_next   = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          Stall       = 1'b1;
          mem_req     = 1'b1;
          mem_addr    = {Address[31:IDX_LO], r_beat, 2'b00};
          w_wr_offset = r_beat;
          w_wr_word   = mem_rdata;
          w_word_we   = mem_ready;
          if (mem_ready && w_last) begin
            w_tag_we    = 1'b1;
            w_tag_valid = 1'b1;
            w_next      = S_IDLE;
          end
        end
        S_WRITE: begin
          Stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {r_addr, 2'b00};
          mem_wdata = r_wdata;
          w_word_we = mem_ready && w_hit;
          if (mem_ready) begin
            w_next = S_WDONE;
          end
        end
        S_WDONE: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a write-through reference (flat memory plus line valid/tag)
// predicts load data and memory traffic; a negedge monitor compares what the DUT presents.
module tb_data_cache;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_Data;
  logic [31:0] Read_data;
  logic        Stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggling, 2: random

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } mtxn_t;

  mtxn_t       mq[$];
  logic [31:0] rd_q[$];
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  bit          hold_pending = 1'b0;
  logic [31:0] hold_addr;

  data_cache #(.LINES(16), .WORDS(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .Write_Data(Write_Data),
    .Read_data (Read_data),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready pattern for the coming edge is chosen just after each rising edge.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ~mem_ready;
        default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Backing memory and scoreboard monitor.
  always @(negedge CLK) begin
    mtxn_t t;
    if (!RESET) begin
      if (hold_pending && mem_req) begin
        check("addr_hold", mem_addr, hold_addr);
      end
      hold_pending = mem_req && !mem_ready;
      hold_addr    = mem_addr;
      if (mem_req && mem_ready) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got we=%0b addr %08h, required no request", mem_we, mem_addr);
        end else begin
          t = mq.pop_front();
          check("mem_we", {31'b0, mem_we}, {31'b0, t.we});
          check("mem_addr", mem_addr, t.addr);
          if (t.we) check("mem_wdata", mem_wdata, t.data);
        end
        if (mem_we) phys_mem[mem_addr] = mem_wdata;
      end
      if (MemRead && !MemWrite && !Stall) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got %08h, required no load completion", Read_data);
        end else begin
          check("Read_data", Read_data, rd_q.pop_front());
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
    mem_rdata = mem_ready ? phys_rd(mem_addr) : 32'hBAD0_BAD0;
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // kind: 0 load, 1 store, 2 both requests (behaves as store). Entered at posedge+1.
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] wa;
    int          idx, exp_stall, stalls;
    logic [23:0] tg;
    wa  = {addr[31:2], 2'b00};
    idx = int'(addr[7:4]);
    tg  = addr[31:8];
    if (kind == 0) begin
      if (m_valid[idx] && m_tag[idx] == tg) begin
        exp_stall = 0;
      end else begin
        exp_stall = 5;
        for (int b = 0; b < 4; b++) mq.push_back('{we: 1'b0, addr: {addr[31:4], 4'(b * 4)}, data: 32'h0});
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
      rd_q.push_back(ref_rd(wa));
    end else begin
      exp_stall = 2;
      mq.push_back('{we: 1'b1, addr: wa, data: data});
      ref_mem[wa] = data;
    end
    MemRead    = (kind != 1);
    MemWrite   = (kind != 0);
    Address    = addr;
    Write_Data = data;
    stalls     = 0;
    forever begin
      @(negedge CLK);
      if (!Stall) break;
      stalls++;
      if (stalls > 200) begin
        errors++;
        checks++;
        $display("FAIL stall_timeout: got %0d stall cycles, required %0d", stalls, exp_stall);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "stall never released");
      end
    end
    if (ready_mode == 0) check("stall_cycles", stalls, exp_stall);
    @(posedge CLK);
    #1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = $urandom;
    Write_Data = $urandom;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    check("idle_stall", {31'b0, Stall}, 32'h0);
    check("idle_mem_req", {31'b0, mem_req}, 32'h0);
    check("idle_read_data", Read_data, 32'h0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    RESET      = 1'b1;
    MemRead    = 1'b1;
    MemWrite   = 1'b0;
    Address    = 32'h100;
    Write_Data = 32'h0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      phys_mem[32'h100 + 4 * i] = 32'hA0 + i;
      ref_mem[32'h100 + 4 * i]  = 32'hA0 + i;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_stall", {31'b0, Stall}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_read_data", Read_data, 32'h0);
    @(posedge CLK);
    #1;
    RESET   = 1'b0;
    MemRead = 1'b0;
    idle_cycle();

    // Cold miss, hit, store hit, store miss without allocate.
    do_op(0, 32'h100, 32'h0);
    idle_cycle();
    do_op(0, 32'h108, 32'h0);
    idle_cycle();
    do_op(1, 32'h104, 32'hDEAD);
    idle_cycle();
    do_op(0, 32'h104, 32'h0);
    idle_cycle();
    do_op(1, 32'h900, 32'h1234);
    idle_cycle();
    do_op(0, 32'h900, 32'h0);
    idle_cycle();

    // Reset two beats into a refill of 0x200.
    mq.push_back('{we: 1'b0, addr: 32'h200, data: 32'h0});
    mq.push_back('{we: 1'b0, addr: 32'h204, data: 32'h0});
    MemRead = 1'b1;
    Address = 32'h200;
    repeat (3) @(posedge CLK);
    #1;
    RESET   = 1'b1;
    MemRead = 1'b0;
    @(negedge CLK);
    check("abort_mem_req_rst", {31'b0, mem_req}, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    check("abort_beats_left", mq.size(), 32'h0);
    idle_cycle();
    do_op(0, 32'h200, 32'h0);
    idle_cycle();

    // Conflicting lines with a toggling ready.
    ready_mode = 1;
    do_op(0, 32'h100, 32'h0);
    idle_cycle();
    do_op(0, 32'h500, 32'h0);
    idle_cycle();
    do_op(0, 32'h100, 32'h0);
    idle_cycle();

    // Random mix over a small footprint so hits, conflicts and store hits all occur.
    for (int n = 0; n < 250; n++) begin
      ready_mode = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      k = $urandom_range(0, 9);
      do_op((k < 6) ? 0 : ((k < 9) ? 1 : 2), a, $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    ready_mode = 0;
    repeat (3) idle_cycle();
    check("rd_q_drained", rd_q.size(), 32'h0);
    check("mq_drained", mq.size(), 32'h0);
    finish_run();
  end

endmodule
